// File: rtl/ni_flit_tx_pkg.sv
// Shared NoC widths and flit tag encodings for the NI transmit path.
package ni_flit_tx_pkg;

    localparam int FLITWD        = 32;
    localparam int FTYPEWD       = 2;
    localparam int COUNTERFLITWD = 4;
    localparam int NI_CREDWD     = 4;

    // Tag bit 1 marks the first flit of a packet, bit 0 the last.
    localparam logic [FTYPEWD-1:0] ENC_PAYL = 2'b00;
    localparam logic [FTYPEWD-1:0] ENC_TAIL = 2'b01;
    localparam logic [FTYPEWD-1:0] ENC_HEAD = 2'b10;
    localparam logic [FTYPEWD-1:0] ENC_SING = 2'b11;

endpackage

// File: rtl/ni_flit_tx_type.sv
// Combinational flit tagger: derives HEAD/PAYL/TAIL/SING from position in packet.
// A flit_sequence other than ENC_SING forces that tag straight through.
module ni_flit_type
    import ni_flit_tx_pkg::*;
(
    input  logic [FTYPEWD-1:0]       flit_sequence,
    input  logic [COUNTERFLITWD-1:0] flit_cnt,
    input  logic [COUNTERFLITWD-1:0] num_flits,
    output logic [FTYPEWD-1:0]       flit_type
);

    // Classify the current flit from its index and the packet length.
    always_comb begin
        flit_type = ENC_PAYL;
        if (flit_sequence != ENC_SING)
            flit_type = flit_sequence;
        else if (num_flits == COUNTERFLITWD'(1))
            flit_type = ENC_SING;
        else if (flit_cnt == '0)
            flit_type = ENC_HEAD;
        else if (flit_cnt == num_flits - COUNTERFLITWD'(1))
            flit_type = ENC_TAIL;
        else
            flit_type = ENC_PAYL;
    end

endmodule

// File: rtl/ni_flit_tx.sv
// NI transmit sequencer: accepts a packet descriptor, streams its flits to the
// switch one per cycle under credit-based flow control, tagging each flit.
module ni_flit_tx
    import ni_flit_tx_pkg::*;
#(
    parameter int CREDITS = 4,
    parameter int CREDWD  = NI_CREDWD
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     pkt_req,
    input  logic [COUNTERFLITWD-1:0] pkt_num_flits,
    output logic                     pkt_ack,
    input  logic [FLITWD-1:0]        data_in,
    input  logic                     data_valid,
    output logic                     data_ready,
    output logic [FLITWD-1:0]        flit_out,
    output logic [FTYPEWD-1:0]       flit_type_out,
    output logic                     flit_valid,
    input  logic                     credit_in,
    output logic                     busy,
    output logic                     credit_err
);

    localparam logic [CREDWD-1:0] CRED_MAX = CREDWD'(CREDITS);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                   state;
    logic [CREDWD-1:0]        credits;
    logic [COUNTERFLITWD-1:0] flit_cnt;
    logic [COUNTERFLITWD-1:0] num_r;
    logic [FTYPEWD-1:0]       next_type;
    logic                     xfer;

    assign data_ready = (state == SEND) && (credits != '0);
    assign xfer       = data_valid && data_ready;
    assign busy       = (state != IDLE);

    ni_flit_type u_flit_type (
        .flit_sequence (ENC_SING),
        .flit_cnt      (flit_cnt),
        .num_flits     (num_r),
        .flit_type     (next_type)
    );

    // Packet FSM plus registered flit outputs; flit_out/type hold when idle.
    // pkt_ack gates a second acceptance while the requester still holds pkt_req.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            flit_cnt      <= '0;
            num_r         <= '0;
            pkt_ack       <= 1'b0;
            flit_valid    <= 1'b0;
            flit_out      <= '0;
            flit_type_out <= ENC_TAIL;
        end else begin
            pkt_ack    <= 1'b0;
            flit_valid <= xfer;
            if (xfer) begin
                flit_out      <= data_in;
                flit_type_out <= next_type;
            end
            case (state)
                IDLE: begin
                    if (pkt_req && !pkt_ack) begin
                        pkt_ack <= 1'b1;
                        if (pkt_num_flits != '0) begin
                            num_r    <= pkt_num_flits;
                            flit_cnt <= '0;
                            state    <= SEND;
                        end
                    end
                end
                SEND: begin
                    if (xfer) begin
                        flit_cnt <= flit_cnt + 1'b1;
                        if (flit_cnt == num_r - 1'b1)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Credit counter: returns add, transfers subtract, overflow flags an error.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            credits    <= CRED_MAX;
            credit_err <= 1'b0;
        end else begin
            case ({credit_in, xfer})
                2'b10: begin
                    if (credits == CRED_MAX)
                        credit_err <= 1'b1;
                    else
                        credits <= credits + 1'b1;
                end
                2'b01:   credits <= credits - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ni_flit_tx.sv
// Directed self-checking bench for ni_flit_tx (CREDITS=4).
module tb_ni_flit_tx;
    import ni_flit_tx_pkg::*;

    logic                     clock = 1'b0;
    logic                     reset_n = 1'b1;
    logic                     pkt_req = 1'b0;
    logic [COUNTERFLITWD-1:0] pkt_num_flits = '0;
    logic                     pkt_ack;
    logic [FLITWD-1:0]        data_in = '0;
    logic                     data_valid = 1'b0;
    logic                     data_ready;
    logic [FLITWD-1:0]        flit_out;
    logic [FTYPEWD-1:0]       flit_type_out;
    logic                     flit_valid;
    logic                     credit_in = 1'b0;
    logic                     busy;
    logic                     credit_err;

    int checks = 0;
    int failures = 0;

    ni_flit_tx #(.CREDITS(4), .CREDWD(4)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .pkt_req       (pkt_req),
        .pkt_num_flits (pkt_num_flits),
        .pkt_ack       (pkt_ack),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .flit_out      (flit_out),
        .flit_type_out (flit_type_out),
        .flit_valid    (flit_valid),
        .credit_in     (credit_in),
        .busy          (busy),
        .credit_err    (credit_err)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        step();
        step();
        if (pkt_ack !== 1'b0) begin failures++; $display("FAIL rst_ack: got %0h want 0", pkt_ack); end checks++;
        if (data_ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got %0h want 0", data_ready); end checks++;
        if (flit_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %0h want 0", flit_valid); end checks++;
        if (flit_out !== 32'h0) begin failures++; $display("FAIL rst_flit: got %0h want 0", flit_out); end checks++;
        if (flit_type_out !== ENC_TAIL) begin failures++; $display("FAIL rst_type: got %0h want %0h", flit_type_out, ENC_TAIL); end checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %0h want 0", busy); end checks++;
        if (credit_err !== 1'b0) begin failures++; $display("FAIL rst_err: got %0h want 0", credit_err); end checks++;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        pkt_req = 1'b1; pkt_num_flits = 4'd1;
        step();
        if (pkt_ack !== 1'b1) begin failures++; $display("FAIL single_ack: got %0h want 1", pkt_ack); end checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %0h want 1", busy); end checks++;
        if (data_ready !== 1'b1) begin failures++; $display("FAIL single_ready: got %0h want 1", data_ready); end checks++;
        pkt_req = 1'b0; data_valid = 1'b1; data_in = 32'hA5;
        step();
        if (flit_valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %0h want 1", flit_valid); end checks++;
        if (flit_out !== 32'hA5) begin failures++; $display("FAIL single_data: got %0h want a5", flit_out); end checks++;
        if (flit_type_out !== ENC_SING) begin failures++; $display("FAIL single_type: got %0h want %0h", flit_type_out, ENC_SING); end checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL single_idle: got %0h want 0", busy); end checks++;
        if (pkt_ack !== 1'b0) begin failures++; $display("FAIL single_ackpulse: got %0h want 0", pkt_ack); end checks++;
        data_valid = 1'b0; data_in = 32'hFF;
        step();
        if (flit_valid !== 1'b0) begin failures++; $display("FAIL single_novalid: got %0h want 0", flit_valid); end checks++;
        if (flit_out !== 32'hA5) begin failures++; $display("FAIL single_hold: got %0h want a5", flit_out); end checks++;
        credit_in = 1'b1;
        step();
        credit_in = 1'b0;
    endtask

    task automatic test_four();
        logic [FTYPEWD-1:0] exp4 [4];
        exp4 = '{ENC_HEAD, ENC_PAYL, ENC_PAYL, ENC_TAIL};
        pkt_req = 1'b1; pkt_num_flits = 4'd4;
        step();
        if (pkt_ack !== 1'b1) begin failures++; $display("FAIL four_ack: got %0h want 1", pkt_ack); end checks++;
        pkt_req = 1'b0; data_valid = 1'b1; data_in = 32'h10;
        for (int i = 0; i < 4; i++) begin
            step();
            if (flit_valid !== 1'b1) begin failures++; $display("FAIL four_valid%0d: got %0h want 1", i, flit_valid); end checks++;
            if (flit_type_out !== exp4[i]) begin failures++; $display("FAIL four_type%0d: got %0h want %0h", i, flit_type_out, exp4[i]); end checks++;
            if (flit_out !== 32'h10 + i) begin failures++; $display("FAIL four_data%0d: got %0h want %0h", i, flit_out, 32'h10 + i); end checks++;
            data_in = 32'h11 + i;
        end
        data_valid = 1'b0;
        if (data_ready !== 1'b0) begin failures++; $display("FAIL four_ready: got %0h want 0", data_ready); end checks++;
        step();
        if (flit_valid !== 1'b0) begin failures++; $display("FAIL four_end: got %0h want 0", flit_valid); end checks++;
    endtask

    // Credits start at 0 here; one credit returns every third cycle.
    task automatic test_credit_stall();
        logic [FTYPEWD-1:0] exp5 [5];
        int cred, sent, stalls;
        logic xf, ci;
        exp5 = '{ENC_HEAD, ENC_PAYL, ENC_PAYL, ENC_PAYL, ENC_TAIL};
        pkt_req = 1'b1; pkt_num_flits = 4'd5;
        step();
        if (pkt_ack !== 1'b1) begin failures++; $display("FAIL stall_ack: got %0h want 1", pkt_ack); end checks++;
        if (data_ready !== 1'b0) begin failures++; $display("FAIL stall_nocred: got %0h want 0", data_ready); end checks++;
        pkt_req = 1'b0; data_valid = 1'b1; data_in = 32'h20;
        cred = 0; sent = 0; stalls = 0;
        for (int c = 0; c < 40 && sent < 5; c++) begin
            xf = (cred != 0);
            ci = ((c % 3) == 0);
            if (data_ready !== xf) begin failures++; $display("FAIL stall_ready%0d: got %0h want %0h", c, data_ready, xf); end checks++;
            if (!xf) stalls++;
            credit_in = ci;
            step();
            if (xf) begin
                if (flit_valid !== 1'b1) begin failures++; $display("FAIL stall_valid%0d: got %0h want 1", sent, flit_valid); end checks++;
                if (flit_type_out !== exp5[sent]) begin failures++; $display("FAIL stall_type%0d: got %0h want %0h", sent, flit_type_out, exp5[sent]); end checks++;
                if (flit_out !== 32'h20 + sent) begin failures++; $display("FAIL stall_data%0d: got %0h want %0h", sent, flit_out, 32'h20 + sent); end checks++;
                sent++;
            end else begin
                if (flit_valid !== 1'b0) begin failures++; $display("FAIL stall_idle%0d: got %0h want 0", c, flit_valid); end checks++;
            end
            cred = cred + int'(ci) - int'(xf);
            data_in = 32'h20 + sent;
        end
        credit_in = 1'b0; data_valid = 1'b0;
        if (sent != 5) begin failures++; $display("FAIL stall_timeout: got %0d flits want 5", sent); end checks++;
        if (stalls == 0) begin failures++; $display("FAIL stall_seen: got %0d stalls want >0", stalls); end checks++;
        step();
    endtask

    // Credits are 0 on entry; ends with exactly 1 credit.
    task automatic test_simultaneous();
        pkt_req = 1'b1; pkt_num_flits = 4'd2;
        step();
        if (pkt_ack !== 1'b1) begin failures++; $display("FAIL sim_ack: got %0h want 1", pkt_ack); end checks++;
        if (data_ready !== 1'b0) begin failures++; $display("FAIL sim_ready0: got %0h want 0", data_ready); end checks++;
        pkt_req = 1'b0; data_valid = 1'b1; data_in = 32'h31; credit_in = 1'b1;
        step();
        if (flit_valid !== 1'b0) begin failures++; $display("FAIL sim_noflit: got %0h want 0", flit_valid); end checks++;
        if (data_ready !== 1'b1) begin failures++; $display("FAIL sim_ready1: got %0h want 1", data_ready); end checks++;
        credit_in = 1'b0;
        step();
        if (flit_valid !== 1'b1) begin failures++; $display("FAIL sim_valid: got %0h want 1", flit_valid); end checks++;
        if (flit_type_out !== ENC_HEAD) begin failures++; $display("FAIL sim_head: got %0h want %0h", flit_type_out, ENC_HEAD); end checks++;
        if (flit_out !== 32'h31) begin failures++; $display("FAIL sim_data: got %0h want 31", flit_out); end checks++;
        if (data_ready !== 1'b0) begin failures++; $display("FAIL sim_cred0: got %0h want 0", data_ready); end checks++;
        credit_in = 1'b1; data_in = 32'h32;
        step();
        if (flit_valid !== 1'b0) begin failures++; $display("FAIL sim_stall: got %0h want 0", flit_valid); end checks++;
        if (data_ready !== 1'b1) begin failures++; $display("FAIL sim_cred1: got %0h want 1", data_ready); end checks++;
        step();
        if (flit_valid !== 1'b1) begin failures++; $display("FAIL sim_valid2: got %0h want 1", flit_valid); end checks++;
        if (flit_type_out !== ENC_TAIL) begin failures++; $display("FAIL sim_tail: got %0h want %0h", flit_type_out, ENC_TAIL); end checks++;
        if (flit_out !== 32'h32) begin failures++; $display("FAIL sim_data2: got %0h want 32", flit_out); end checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL sim_idle: got %0h want 0", busy); end checks++;
        credit_in = 1'b0; data_valid = 1'b0;
        step();
    endtask

    // Credits are 1 on entry: three returns fill to 4, the fourth overflows.
    task automatic test_zero_and_err();
        pkt_req = 1'b1; pkt_num_flits = 4'd0; data_valid = 1'b1; data_in = 32'h77;
        step();
        if (pkt_ack !== 1'b1) begin failures++; $display("FAIL zero_ack: got %0h want 1", pkt_ack); end checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy: got %0h want 0", busy); end checks++;
        if (data_ready !== 1'b0) begin failures++; $display("FAIL zero_ready: got %0h want 0", data_ready); end checks++;
        pkt_req = 1'b0;
        step();
        if (pkt_ack !== 1'b0) begin failures++; $display("FAIL zero_ackpulse: got %0h want 0", pkt_ack); end checks++;
        if (flit_valid !== 1'b0) begin failures++; $display("FAIL zero_noflit: got %0h want 0", flit_valid); end checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy2: got %0h want 0", busy); end checks++;
        data_valid = 1'b0; credit_in = 1'b1;
        step(); step(); step();
        if (credit_err !== 1'b0) begin failures++; $display("FAIL err_early: got %0h want 0", credit_err); end checks++;
        step();
        if (credit_err !== 1'b1) begin failures++; $display("FAIL err_set: got %0h want 1", credit_err); end checks++;
        credit_in = 1'b0;
        step(); step();
        if (credit_err !== 1'b1) begin failures++; $display("FAIL err_sticky: got %0h want 1", credit_err); end checks++;
    endtask

    task automatic test_reset_mid();
        pkt_req = 1'b1; pkt_num_flits = 4'd4;
        step();
        if (pkt_ack !== 1'b1) begin failures++; $display("FAIL mid_ack: got %0h want 1", pkt_ack); end checks++;
        pkt_req = 1'b0; data_valid = 1'b1; data_in = 32'h40;
        step();
        data_in = 32'h41;
        step();
        if (flit_type_out !== ENC_PAYL) begin failures++; $display("FAIL mid_payl: got %0h want %0h", flit_type_out, ENC_PAYL); end checks++;
        data_in = 32'h42;
        #2 reset_n = 1'b0;
        #1;
        if (flit_valid !== 1'b0) begin failures++; $display("FAIL mid_valid: got %0h want 0", flit_valid); end checks++;
        if (flit_out !== 32'h0) begin failures++; $display("FAIL mid_flit: got %0h want 0", flit_out); end checks++;
        if (flit_type_out !== ENC_TAIL) begin failures++; $display("FAIL mid_type: got %0h want %0h", flit_type_out, ENC_TAIL); end checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy: got %0h want 0", busy); end checks++;
        if (data_ready !== 1'b0) begin failures++; $display("FAIL mid_ready: got %0h want 0", data_ready); end checks++;
        if (credit_err !== 1'b0) begin failures++; $display("FAIL mid_err: got %0h want 0", credit_err); end checks++;
        data_valid = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        pkt_req = 1'b1; pkt_num_flits = 4'd2;
        step();
        if (pkt_ack !== 1'b1) begin failures++; $display("FAIL post_ack: got %0h want 1", pkt_ack); end checks++;
        pkt_req = 1'b0; data_valid = 1'b1; data_in = 32'h50;
        step();
        if (flit_type_out !== ENC_HEAD) begin failures++; $display("FAIL post_head: got %0h want %0h", flit_type_out, ENC_HEAD); end checks++;
        if (flit_out !== 32'h50) begin failures++; $display("FAIL post_data0: got %0h want 50", flit_out); end checks++;
        data_in = 32'h51;
        step();
        if (flit_type_out !== ENC_TAIL) begin failures++; $display("FAIL post_tail: got %0h want %0h", flit_type_out, ENC_TAIL); end checks++;
        if (flit_out !== 32'h51) begin failures++; $display("FAIL post_data1: got %0h want 51", flit_out); end checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL post_idle: got %0h want 0", busy); end checks++;
        data_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_four();
        test_credit_stall();
        test_simultaneous();
        test_zero_and_err();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ni_flit_tx.md
# ni_flit_tx

Transmit sequencer of the network interface: accepts a packet descriptor (flit count) from the NI packetizer, streams the packet's data words onto the NoC output link one flit per cycle, and tags each flit HEAD/PAYL/TAIL/SING. Sits between the NI packetizer and the switch input port. Flow control is credit-based: one credit per free slot in the downstream switch buffer. The per-flit tag is produced by the existing combinational `ni_flit_type`, driven from this block's flit counter.

## Interface
Parameters:
- CREDITS, 4: downstream buffer depth; initial and maximum credit count (1..15).
- CREDWD, 4: credit counter width; must hold CREDITS.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pkt_req  in  1  packet descriptor valid; held by requester until pkt_ack.
- pkt_num_flits  in  `COUNTERFLITWD  flits in packet; sampled at acceptance.
- pkt_ack  out  1  one-cycle pulse: descriptor accepted.
- data_in  in  `FLITWD  flit payload from packetizer.
- data_valid  in  1  data_in valid.
- data_ready  out  1  block takes data_in this cycle when data_valid is also high.
- flit_out  out  `FLITWD  registered flit to switch.
- flit_type_out  out  `FTYPEWD  registered flit tag (`ENC_HEAD/`ENC_PAYL/`ENC_TAIL/`ENC_SING).
- flit_valid  out  1  flit_out valid; one flit per high cycle.
- credit_in  in  1  one credit returned by switch this cycle.
- busy  out  1  state != IDLE.
- credit_err  out  1  sticky; credit returned while counter at CREDITS.

## Operation
- FSM states: IDLE, SEND.
- IDLE, pkt_req=1, pkt_num_flits>0:
  - latch num into num_r; clear flit_cnt.
  - pulse pkt_ack; go to SEND.
- IDLE, pkt_req=1, pkt_num_flits=0:
  - pulse pkt_ack; stay IDLE; no flits emitted.
- SEND:
  - data_ready = (credits != 0), combinational.
  - Transfer = data_valid && data_ready.
  - On transfer, next cycle: flit_out = data_in, flit_type_out = ni_flit_type(`ENC_SING, flit_cnt, num_r), flit_valid=1.
  - Also on transfer: flit_cnt++, credits--.
  - Transfer with flit_cnt == num_r-1 returns the FSM to IDLE.
- No transfer: flit_valid=0; flit_out/flit_type_out hold their previous values.
- Tag sequence:
  - num=1: SING.
  - num=2: HEAD, TAIL.
  - num≥3: HEAD, PAYL…, TAIL.
- Credits:
  - +1 on credit_in, -1 on transfer; both in the same cycle: unchanged.
  - credit_in at CREDITS with no transfer: counter saturates, credit_err set.
- data_ready is 0 in IDLE; data_valid is ignored there.
- Arithmetic: flit_cnt is `COUNTERFLITWD wide and never wraps (bounded by num_r-1).

## Timing
- Reset values:
  - state=IDLE, credits=CREDITS, flit_cnt=0, num_r=0.
  - pkt_ack=0, data_ready=0, flit_valid=0, flit_out=0, flit_type_out=`ENC_TAIL, busy=0, credit_err=0.
- pkt_ack: registered; high the cycle after pkt_req is sampled in IDLE. busy rises in the same cycle.
- Latency: data_in to flit_out is 1 cycle.
- Throughput: 1 flit/cycle while credits are available.
- Packet gap: at least one IDLE cycle between packets.
- credit_in affects data_ready the cycle after it is sampled.
- Reset mid-packet: immediate abort.
  - Partial packet is not terminated with TAIL; the downstream switch is reset in the same domain.
  - Credits return to CREDITS.

## Structure
- State encoding localparams stay local.
- `ENC_*`, `FTYPEWD`, `FLITWD`, `COUNTERFLITWD` come from the shared noc_parameters.v include.
- CREDWD is added to noc_parameters.v as `NI_CREDWD`.
- Sub-module: one instance of `ni_flit_type`, with flit_sequence tied to `ENC_SING`; no other hierarchy.

## Test plan
- 1-flit packet, CREDITS=4, data 0xA5 → one flit_valid, flit_type_out=SING, pkt_ack 1 cycle after req, busy low after the flit.
- 4-flit packet, data_valid continuous, no credit return → HEAD, PAYL, PAYL, TAIL on 4 consecutive cycles; credits end at 0; data_ready low afterwards.
- CREDITS=2, 5-flit packet, credit_in pulsed every 3 cycles → never more than 2 outstanding flits; tags HEAD, PAYL, PAYL, PAYL, TAIL; stalls visible as data_ready=0.
- Credits=0, credit_in and transfer opportunity in the same cycle → next cycle exactly one flit sent, credits=0; with credits=1, simultaneous credit_in and transfer keeps credits=1.
- pkt_num_flits=0 → pkt_ack pulse, no flit_valid, FSM stays IDLE; an extra credit_in at full credits → credit_err=1 and stays set.
- reset_n low after flit 2 of 4 → all outputs return to reset values asynchronously; a new 2-flit packet then emits HEAD, TAIL.
